dpi_stream_sequencer: RTL and testbench

Upstream feeder for the per-category regex wrappers. It accepts a flow header followed by a payload byte stream, maps the 32-bit flow key to a 6-bit stream ID through a 64-entry table, and emits the `load_state` / `char_in` / `eop` sequence those wrappers expect. Its timing guarantees that each wrapper restores its DFA state before the first byte arrives, and saves it only after the last byte has drained through the wrapper pipeline.

---
 rtl/dpi_stream_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - flow header/payload sequencer feeding the category regex wrappers
// Define STREAM_EVICT_EN to recycle table entries round-robin once all 64 are in use.
module dpi_stream_sequencer #(
  parameter int NUM_CAT      = 8,
  parameter int LOAD_GAP     = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hdr_vld,
  input  logic [31:0]        hdr_flow,
  output logic               hdr_rdy,
  input  logic               pkt_vld,
  input  logic [7:0]         pkt_data,
  input  logic               pkt_last,
  output logic               pkt_rdy,
  input  logic [NUM_CAT-1:0] cfg_cat_enable,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               load_state,
  output logic [5:0]         stream_id,
  output logic               new_stream_id,
  output logic               eop,
  output logic [NUM_CAT-1:0] enable,
  output logic [15:0]        pkt_count,
  output logic [15:0]        new_count
);

  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP} state_t;

  localparam logic [2:0] GAP_LAST   = 3'(LOAD_GAP - 3);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES);

  state_t             state;
  logic [63:0]        valid;
  logic [31:0]        keys [64];
  logic [31:0]        flow_q;
  logic [NUM_CAT-1:0] en_q;
  logic [2:0]         gap_cnt;
  logic [3:0]         drain_cnt;
  logic               hit;
  logic [5:0]         hit_idx;
  logic               has_free;
  logic [5:0]         free_idx;
  logic               key_we;
  logic [5:0]         key_widx;

  // Descending scan so the last assignment leaves the lowest index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (valid[i] && keys[i] == flow_q) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = 6'(i);
      end
    end
  end

`ifdef STREAM_EVICT_EN
  logic [5:0] evict_ptr;
  assign key_we   = (state == LOOKUP) && rst_n && !hit;
  assign key_widx = has_free ? free_idx : evict_ptr;
`else
  assign key_we   = (state == LOOKUP) && rst_n && !hit && has_free;
  assign key_widx = free_idx;
`endif

  // Keys need no reset: an entry only matters once its valid bit is set.
  always_ff @(posedge clk) begin
    if (key_we) keys[key_widx] <= flow_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= '0;
      hdr_rdy       <= 1'b0;
      pkt_rdy       <= 1'b0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      load_state    <= 1'b0;
      eop           <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      enable        <= '0;
      pkt_count     <= '0;
      new_count     <= '0;
      flow_q        <= '0;
      en_q          <= '0;
      gap_cnt       <= '0;
      drain_cnt     <= '0;
`ifdef STREAM_EVICT_EN
      evict_ptr     <= '0;
`endif
    end else begin
      load_state  <= 1'b0;
      eop         <= 1'b0;
      char_in_vld <= 1'b0;
      case (state)
        IDLE: begin
          hdr_rdy <= 1'b1;
          if (hdr_vld && hdr_rdy) begin
            flow_q  <= hdr_flow;
            en_q    <= cfg_cat_enable;
            hdr_rdy <= 1'b0;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          load_state <= 1'b1;
          enable     <= en_q;
          state      <= LOAD;
          if (hit) begin
            stream_id     <= hit_idx;
            new_stream_id <= 1'b0;
          end else if (has_free) begin
            stream_id       <= free_idx;
            new_stream_id   <= 1'b1;
            valid[free_idx] <= 1'b1;
            new_count       <= new_count + 16'd1;
          end else begin
`ifdef STREAM_EVICT_EN
            stream_id     <= evict_ptr;
            new_stream_id <= 1'b1;
            evict_ptr     <= evict_ptr + 6'd1;
            new_count     <= new_count + 16'd1;
`else
            stream_id     <= '0;
            new_stream_id <= 1'b1;
            enable        <= '0;
`endif
          end
        end
        // The first byte is accepted LOAD_GAP-1 cycles after load_state so it lands on char_in exactly LOAD_GAP later.
        LOAD: begin
          gap_cnt <= '0;
          if (LOAD_GAP > 2) begin
            state <= GAP;
          end else begin
            state   <= STREAM;
            pkt_rdy <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= STREAM;
            pkt_rdy <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
        STREAM: begin
          if (pkt_vld && pkt_rdy) begin
            char_in     <= pkt_data;
            char_in_vld <= 1'b1;
            if (pkt_last) begin
              pkt_rdy   <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            eop       <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
            state     <= EOP;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        EOP: begin
          hdr_rdy <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb/tb_dpi_stream_sequencer.sv - directed scoreboard bench for dpi_stream_sequencer
module tb_dpi_stream_sequencer;

  localparam int LOAD_GAP     = 2;
  localparam int DRAIN_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hdr_vld;
  logic [31:0] hdr_flow;
  logic        hdr_rdy;
  logic        pkt_vld;
  logic [7:0]  pkt_data;
  logic        pkt_last;
  logic        pkt_rdy;
  logic [7:0]  cfg_cat_enable;
  logic [7:0]  char_in;
  logic        char_in_vld;
  logic        load_state;
  logic [5:0]  stream_id;
  logic        new_stream_id;
  logic        eop;
  logic [7:0]  enable;
  logic [15:0] pkt_count;
  logic [15:0] new_count;

  dpi_stream_sequencer #(.NUM_CAT(8), .LOAD_GAP(LOAD_GAP), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_vld(hdr_vld), .hdr_flow(hdr_flow), .hdr_rdy(hdr_rdy),
    .pkt_vld(pkt_vld), .pkt_data(pkt_data), .pkt_last(pkt_last), .pkt_rdy(pkt_rdy),
    .cfg_cat_enable(cfg_cat_enable),
    .char_in(char_in), .char_in_vld(char_in_vld), .load_state(load_state),
    .stream_id(stream_id), .new_stream_id(new_stream_id), .eop(eop),
    .enable(enable), .pkt_count(pkt_count), .new_count(new_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sid;
    logic       nw;
    logic [7:0] en;
  } exp_t;

  exp_t       pq[$];
  logic [7:0] bq[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc_n = 0;
  int         hdr_cyc = 0;
  int         load_cyc = 0;
  int         last_char_cyc = 0;
  int         eop_count = 0;
  bit         first_pending = 0;
  bit         gap_exact = 0;
  logic [5:0] cur_sid = '0;
  int         exp_pkts = 0;
  int         exp_new = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic [7:0] b;
    if (load_state) begin
      chk("hdr_to_load", 32'(cyc_n - hdr_cyc), 32'd2);
      if (pq.size() == 0) begin
        chk("unexpected_load", 32'(pq.size()), 32'd1);
      end else begin
        e = pq.pop_front();
        chk("stream_id", 32'(stream_id), 32'(e.sid));
        chk("new_stream_id", 32'(new_stream_id), 32'(e.nw));
        chk("enable", 32'(enable), 32'(e.en));
        cur_sid = e.sid;
      end
      load_cyc = cyc_n;
      first_pending = 1;
    end
    if (char_in_vld) begin
      if (bq.size() == 0) begin
        chk("unexpected_char", 32'(bq.size()), 32'd1);
      end else begin
        b = bq.pop_front();
        chk("char_in", 32'(char_in), 32'(b));
      end
      chk("sid_stable", 32'(stream_id), 32'(cur_sid));
      if (first_pending && gap_exact)
        chk("load_gap", 32'(cyc_n - load_cyc), 32'(LOAD_GAP));
      first_pending = 0;
      last_char_cyc = cyc_n;
    end
    if (eop) begin
      chk("eop_delay", 32'(cyc_n - last_char_cyc), 32'(DRAIN_CYCLES + 1));
      eop_count++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    monitor();
  endtask

  task automatic send_hdr(input logic [31:0] key, input logic [7:0] en,
                          input logic [5:0] esid, input logic enew, input logic [7:0] een);
    exp_t e;
    int n;
    e.sid = esid; e.nw = enew; e.en = een;
    pq.push_back(e);
    hdr_vld = 1'b1; hdr_flow = key; cfg_cat_enable = en;
    n = 0;
    while (!hdr_rdy && n < 30) begin cyc(); n++; end
    if (!hdr_rdy) chk("hdr_rdy_timeout", 32'(hdr_rdy), 32'd1);
    hdr_cyc = cyc_n;
    cyc();
    hdr_vld = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] key, input logic [7:0] en, input int nbytes,
                          input logic [7:0] seed, input bit stall,
                          input logic [5:0] esid, input logic enew, input logic [7:0] een);
    int  n;
    int  e0;
    bit  acc;
    bit  tog;
    gap_exact = !stall;
    for (int i = 0; i < nbytes; i++) bq.push_back(seed + 8'(i));
    send_hdr(key, en, esid, enew, een);
    tog = 1'b1;
    e0 = eop_count;
    for (int i = 0; i < nbytes; i++) begin
      pkt_data = seed + 8'(i);
      pkt_last = (i == nbytes - 1);
      n = 0;
      acc = 0;
      while (!acc && n < 40) begin
        pkt_vld = stall ? tog : 1'b1;
        acc = pkt_vld && pkt_rdy;
        cyc();
        tog = !tog;
        n++;
      end
      if (!acc) chk("pkt_accept_timeout", 32'(pkt_rdy), 32'd1);
    end
    pkt_vld = 1'b0; pkt_last = 1'b0;
    n = 0;
    while (eop_count == e0 && n < 40) begin cyc(); n++; end
    repeat (3) cyc();
    chk("eop_once", 32'(eop_count), 32'(e0 + 1));
    exp_pkts++;
    if (enew) exp_new++;
  endtask

  initial begin
    rst_n = 1'b0; hdr_vld = 1'b0; hdr_flow = '0; pkt_vld = 1'b0;
    pkt_data = '0; pkt_last = 1'b0; cfg_cat_enable = '0;
    repeat (3) cyc();
    chk("rst_hdr_rdy", 32'(hdr_rdy), 32'd0);
    chk("rst_pkt_rdy", 32'(pkt_rdy), 32'd0);
    chk("rst_char_vld", 32'(char_in_vld), 32'd0);
    chk("rst_load", 32'(load_state), 32'd0);
    chk("rst_eop", 32'(eop), 32'd0);
    chk("rst_new", 32'(new_stream_id), 32'd0);
    chk("rst_sid", 32'(stream_id), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_new_count", 32'(new_count), 32'd0);
    chk("rst_char_in", 32'(char_in), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_hdr_rdy", 32'(hdr_rdy), 32'd1);

    // New flow "abcd"
    send_pkt(32'hDEADBEEF, 8'hA5, 4, 8'h61, 0, 6'd0, 1'b1, 8'hA5);
    chk("pkt_count_1", 32'(pkt_count), 32'd1);
    chk("new_count_1", 32'(new_count), 32'd1);

    // Repeat flow, then a second new flow
    send_pkt(32'hDEADBEEF, 8'h3C, 2, 8'h78, 0, 6'd0, 1'b0, 8'h3C);
    send_pkt(32'h12345678, 8'h0F, 3, 8'h30, 0, 6'd1, 1'b1, 8'h0F);
    chk("new_count_2", 32'(new_count), 32'd2);
    chk("pkt_count_3", 32'(pkt_count), 32'd3);

    // Stalled 10-byte packet
    send_pkt(32'hCAFEF00D, 8'h81, 10, 8'h40, 1, 6'd2, 1'b1, 8'h81);
    chk("new_count_3", 32'(new_count), 32'd3);
    chk("pkt_rdy_idle", 32'(pkt_rdy), 32'd0);

    // Fill the table to 64 entries
    for (int i = 3; i < 64; i++)
      send_pkt(32'h5000_0000 + 32'(i), 8'h01, 1, 8'(i), 0, 6'(i), 1'b1, 8'h01);
    chk("new_count_64", 32'(new_count), 32'd64);

    // 65th distinct key, then resend key #1
`ifdef STREAM_EVICT_EN
    send_pkt(32'h7777_0001, 8'hFF, 2, 8'h90, 0, 6'd0, 1'b1, 8'hFF);
    chk("new_count_65", 32'(new_count), 32'd65);
    send_pkt(32'hDEADBEEF, 8'h11, 1, 8'hA0, 0, 6'd1, 1'b1, 8'h11);
    chk("new_count_66", 32'(new_count), 32'd66);
`else
    send_pkt(32'h7777_0001, 8'hFF, 2, 8'h90, 0, 6'd0, 1'b1, 8'h00);
    chk("new_count_full", 32'(new_count), 32'd64);
    send_pkt(32'hDEADBEEF, 8'h11, 1, 8'hA0, 0, 6'd0, 1'b0, 8'h11);
    chk("new_count_still", 32'(new_count), 32'd64);
`endif
    chk("pkt_count_67", 32'(pkt_count), 32'(exp_pkts));

    // Reset mid-packet
    gap_exact = 1;
    bq.push_back(8'hC0);
    bq.push_back(8'hC1);
`ifdef STREAM_EVICT_EN
    send_hdr(32'hDEADBEEF, 8'h22, 6'd1, 1'b0, 8'h22);
`else
    send_hdr(32'hDEADBEEF, 8'h22, 6'd0, 1'b0, 8'h22);
`endif
    begin
      int e0;
      int n;
      bit acc;
      e0 = eop_count;
      pkt_vld = 1'b1; pkt_last = 1'b0;
      for (int i = 0; i < 2; i++) begin
        pkt_data = 8'hC0 + 8'(i);
        n = 0; acc = 0;
        while (!acc && n < 20) begin
          acc = pkt_rdy;
          cyc();
          n++;
        end
      end
      pkt_vld = 1'b0;
      rst_n = 1'b0;
      repeat (2) cyc();
      repeat (6) cyc();
      chk("abort_no_eop", 32'(eop_count), 32'(e0));
      chk("abort_pkt_count", 32'(pkt_count), 32'd0);
      chk("abort_new_count", 32'(new_count), 32'd0);
      chk("abort_sid", 32'(stream_id), 32'd0);
      chk("abort_enable", 32'(enable), 32'd0);
      chk("abort_char_in", 32'(char_in), 32'd0);
      chk("abort_pkt_rdy", 32'(pkt_rdy), 32'd0);
      chk("abort_hdr_rdy", 32'(hdr_rdy), 32'd0);
    end
    rst_n = 1'b1;
    cyc();
    send_pkt(32'hDEADBEEF, 8'h44, 2, 8'hE0, 0, 6'd0, 1'b1, 8'h44);
    chk("post_abort_new_count", 32'(new_count), 32'd1);
    chk("post_abort_pkt_count", 32'(pkt_count), 32'd1);
    chk("bytes_drained", 32'(bq.size()), 32'd0);
    chk("loads_drained", 32'(pq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
